// File: rtl/uart_pkg.sv
// Shared UART frame constants and receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 1 (idle-high line).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, valid/ack byte handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev;
  logic fall;

  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [7:0]           data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 ovr_nxt;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign fall = !rx_s && rx_prev;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      data_out  <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
      rx_prev   <= rx_s;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = data_out;
    valid_nxt   = rx_valid;
    ferr_nxt    = 1'b0;
    ovr_nxt     = 1'b0;

    // Ack is applied first so a byte landing in the same cycle re-asserts valid.
    if (rx_valid && rx_ack) begin
      valid_nxt = 1'b0;
    end

    if (!rx_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (fall) begin
            state_nxt = START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            state_nxt   = rx_s ? IDLE : DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_nxt     = '0;
            shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
              state_nxt = STOP;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (rx_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              ovr_nxt   = rx_valid && !rx_ack;
            end else begin
              ferr_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx driven by a behavioural 8N1 transmitter.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_landed = 0;
  int n_ferr = 0;
  int n_ovr = 0;

  logic [7:0] exp_q[$];

  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .rx_in     (rx_in),
    .rx_ack    (rx_ack),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A byte has landed when rx_valid rises or an overrun pulse overwrites data_out.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if ((rx_valid && !prev_valid) || overrun) begin
      n_landed++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got %02h with no byte expected", data_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b) begin
          errors++;
          $display("FAIL scoreboard_data: got %02h expected %02h", data_out, exp_b);
        end
      end
    end
    if (frame_err) begin
      n_ferr++;
      checks++;
      if (prev_ferr !== 1'b0) begin
        errors++;
        $display("FAIL frame_err_width: high %0d consecutive cycles, expected 1", 2);
      end
    end
    if (overrun) begin
      n_ovr++;
      checks++;
      if (prev_ovr !== 1'b0) begin
        errors++;
        $display("FAIL overrun_width: high %0d consecutive cycles, expected 1", 2);
      end
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_bit(input logic v);
    rx_in = v;
    tick(CPB);
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic stop_v);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop_v);
    rx_in = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data_out); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick(8);
  endtask

  task automatic test_single_byte();
    int l0 = n_landed;
    int f0 = n_ferr;
    tick(8);
    exp_q.push_back(8'hA5);
    tx_frame(8'hA5, 1'b1);
    tick(4);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h expected a5", data_out); end
    checks++; if (n_landed !== l0 + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", n_landed, l0 + 1); end
    checks++; if (n_ferr !== f0) begin errors++; $display("FAIL single_ferr: got %0d expected %0d", n_ferr, f0); end
    tick(10);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_hold: got %b expected 1", rx_valid); end
    ack_pulse();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int l0 = n_landed;
    tick(8);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        tx_frame(8'h00, 1'b1);
        tx_frame(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int waited = 0;
          while (!rx_valid && waited < 400) begin
            tick(1);
            waited++;
          end
          checks++;
          if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait_valid: got %b expected 1 within 400 cycles", rx_valid);
          end else begin
            ack_pulse();
            checks++;
            if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack: got %b expected 0", rx_valid); end
          end
        end
      end
    join
    tick(4);
    checks++; if (n_landed !== l0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", n_landed, l0 + 2); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %02h expected ff", data_out); end
  endtask

  task automatic test_glitch();
    int l0 = n_landed;
    int f0 = n_ferr;
    logic saw_busy = 1'b0;
    tick(8);
    rx_in = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(1); saw_busy |= busy; end
    rx_in = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(1); saw_busy |= busy; end
    tick(40);
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b expected 1", saw_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    checks++; if (n_landed !== l0) begin errors++; $display("FAIL glitch_no_byte: got %0d expected %0d", n_landed, l0); end
    checks++; if (n_ferr !== f0) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected %0d", n_ferr, f0); end
  endtask

  task automatic test_frame_error();
    int l0 = n_landed;
    int f0 = n_ferr;
    tick(8);
    tx_frame(8'h3C, 1'b0);
    tick(4);
    checks++; if (n_ferr !== f0 + 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected %0d", n_ferr, f0 + 1); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept: got %02h expected ff", data_out); end
    checks++; if (n_landed !== l0) begin errors++; $display("FAIL ferr_no_byte: got %0d expected %0d", n_landed, l0); end
  endtask

  task automatic test_overrun();
    int l0 = n_landed;
    int o0 = n_ovr;
    tick(8);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    tx_frame(8'h11, 1'b1);
    tx_frame(8'h22, 1'b1);
    tick(4);
    checks++; if (n_ovr !== o0 + 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected %0d", n_ovr, o0 + 1); end
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL ovr_data: got %02h expected 22", data_out); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    checks++; if (n_landed !== l0 + 2) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", n_landed, l0 + 2); end
    ack_pulse();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_abort(input logic use_rst);
    int l0 = n_landed;
    int f0 = n_ferr;
    logic [7:0] b = 8'h5A;
    tick(8);
    tx_bit(1'b0);
    for (int i = 0; i < 4; i++) tx_bit(b[i]);
    rx_in = b[4];
    tick(CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_midframe_busy: got %b expected 1", busy); end
    if (use_rst) rst = 1'b1;
    else rx_en = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    rx_in = 1'b1;
    tick(CPB * 10);
    rx_en = 1'b1;
    tick(4);
    checks++; if (n_landed !== l0) begin errors++; $display("FAIL abort_no_byte: got %0d expected %0d", n_landed, l0); end
    checks++; if (n_ferr !== f0) begin errors++; $display("FAIL abort_no_ferr: got %0d expected %0d", n_ferr, f0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", rx_valid); end
    if (use_rst) begin
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL abort_rst_data: got %02h expected 00", data_out); end
    end
    exp_q.push_back(8'h5A);
    tx_frame(8'h5A, 1'b1);
    tick(4);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL abort_clean_data: got %02h expected 5a", data_out); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL abort_clean_valid: got %b expected 1", rx_valid); end
    ack_pulse();
  endtask

  initial begin
    rst    = 1'b1;
    rx_en  = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    tick(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_abort(1'b0);
    test_abort(1'b1);
    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending bytes expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
